// File: rtl/bist_pkg.sv
// Shared types and constants for the multi-chain logic BIST controller.
// Holds the FSM state enum, LFSR/MISR mode and the per-width tap table.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    SHIFT,
    CAPTURE,
    UNLOAD,
    COMPARE,
    DONE
  } bist_state_e;

  typedef enum logic {
    PRPG,
    MISR
  } lfsr_mode_e;

  localparam int          DEF_SIG_W = 16;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  // Fibonacci feedback taps, bit k set = x^(k+1) term.
  // Left shift, feedback enters bit 0.
  function automatic logic [31:0] tap_mask(input int w);
    case (w)
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/bist_lfsr_misr.sv
// Shared shift register core: PRPG (free LFSR) or MISR (LFSR ^ data).
// Ports: clk, i_load/i_load_val, i_en, i_data (MISR only), o_state.
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int         SIG_W = DEF_SIG_W,
  parameter lfsr_mode_e MODE  = PRPG,
  parameter int         IN_W  = 1,
  parameter int         OUT_W = SIG_W
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic [SIG_W-1:0] i_load_val,
  input  logic             i_en,
  input  logic [IN_W-1:0]  i_data,
  output logic [OUT_W-1:0] o_state
);

  localparam logic [SIG_W-1:0] TAPS =
    SIG_W'(tap_mask(SIG_W));
  localparam logic [SIG_W-1:0] DMASK =
    (MODE == MISR) ? '1 : '0;

  logic [SIG_W-1:0] r_state;
  logic [SIG_W-1:0] w_shift;
  logic [SIG_W-1:0] w_next;

  assign w_shift = {r_state[SIG_W-2:0],
                    ^(r_state & TAPS)};
  assign w_next  = w_shift ^ (SIG_W'(i_data) & DMASK);

  always_ff @(posedge clk) begin
    if (i_load)
      r_state <= i_load_val;
    else if (i_en)
      r_state <= w_next;
  end

  assign o_state = r_state[OUT_W-1:0];

endmodule

// File: rtl/multi_chain_bist_controller.sv
// Multi-chain scan BIST: PRPG loads, capture, MISR compaction, compare.
// Ports: clk, rst (sync, low), bistmode, bist_learn, cut_sdo/sdi/scanmode, status.
module multi_chain_bist_controller
  import bist_pkg::*;
#(
  parameter int               NUM_CHAINS   = 4,
  parameter int               CHAIN_LEN    = 229,
  parameter int               NUM_PATTERNS = 2000,
  parameter int               SIG_W        = DEF_SIG_W,
  parameter logic [SIG_W-1:0] LFSR_SEED    = SIG_W'(DEF_SEED),
  parameter logic [SIG_W-1:0] GOLDEN_SIG   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bistmode,
  input  logic                  bist_learn,
  input  logic [NUM_CHAINS-1:0] cut_sdo,
  output logic                  cut_scanmode,
  output logic [NUM_CHAINS-1:0] cut_sdi,
  output logic                  bist_busy,
  output logic                  bistdone,
  output logic                  bistpass,
  output logic [SIG_W-1:0]      bist_signature
);

  localparam int SH_W = $clog2(CHAIN_LEN);
  localparam int PC_W = $clog2(NUM_PATTERNS + 1);
  localparam logic [SH_W-1:0] SH_LAST =
    SH_W'(CHAIN_LEN - 1);
  localparam logic [PC_W-1:0] PC_LAST =
    PC_W'(NUM_PATTERNS - 1);

  bist_state_e r_state;
  bist_state_e w_next;

  logic [SH_W-1:0]       r_shcnt;
  logic [PC_W-1:0]       r_patcnt;
  logic                  r_learn;
  logic                  r_pass;
  logic [SIG_W-1:0]      r_golden;
  logic [NUM_CHAINS-1:0] w_lfsr;
  logic [SIG_W-1:0]      w_misr;
  logic                  w_init;
  logic                  w_sh_last;
  logic                  w_misr_en;

  assign w_init    = !rst || (r_state == SEED);
  assign w_sh_last = (r_shcnt == SH_LAST);
  // First load shifts out unknown chain state.
  assign w_misr_en = (r_state == UNLOAD) ||
                     ((r_state == SHIFT) &&
                      (r_patcnt != '0));

  bist_lfsr_misr #(
    .SIG_W (SIG_W),
    .MODE  (PRPG),
    .IN_W  (1),
    .OUT_W (NUM_CHAINS)
  ) u_prpg (
    .clk        (clk),
    .i_load     (w_init),
    .i_load_val (LFSR_SEED),
    .i_en       (r_state == SHIFT),
    .i_data     (1'b0),
    .o_state    (w_lfsr)
  );

  bist_lfsr_misr #(
    .SIG_W (SIG_W),
    .MODE  (MISR),
    .IN_W  (NUM_CHAINS),
    .OUT_W (SIG_W)
  ) u_misr (
    .clk        (clk),
    .i_load     (w_init),
    .i_load_val ('0),
    .i_en       (w_misr_en),
    .i_data     (cut_sdo),
    .o_state    (w_misr)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cut_scanmode = 1'b0;
    bist_busy    = 1'b1;
    bistdone     = 1'b0;
    unique case (r_state)
      IDLE: begin
        bist_busy = 1'b0;
        if (bistmode)
          w_next = SEED;
      end
      SEED:
        w_next = SHIFT;
      SHIFT: begin
        cut_scanmode = 1'b1;
        if (w_sh_last)
          w_next = CAPTURE;
      end
      CAPTURE:
        w_next = (r_patcnt == PC_LAST) ?
                 UNLOAD : SHIFT;
      UNLOAD: begin
        cut_scanmode = 1'b1;
        if (w_sh_last)
          w_next = COMPARE;
      end
      COMPARE:
        w_next = DONE;
      DONE: begin
        bist_busy = 1'b0;
        bistdone  = 1'b1;
        if (!bistmode)
          w_next = IDLE;
      end
      default:
        w_next = IDLE;
    endcase
    if (bist_busy && !bistmode)
      w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shcnt  <= '0;
      r_patcnt <= '0;
      r_learn  <= 1'b0;
      r_pass   <= 1'b0;
      r_golden <= GOLDEN_SIG;
    end else begin
      if ((r_state == IDLE) && bistmode)
        r_learn <= bist_learn;
      if (r_state == SEED) begin
        r_shcnt  <= '0;
        r_patcnt <= '0;
        r_pass   <= 1'b0;
      end
      if ((r_state == SHIFT) ||
          (r_state == UNLOAD))
        r_shcnt <= w_sh_last ? '0 :
                   r_shcnt + 1'b1;
      if (r_state == CAPTURE)
        r_patcnt <= r_patcnt + 1'b1;
      // An abort in COMPARE leaves golden alone.
      if ((r_state == COMPARE) && bistmode) begin
        if (r_learn) begin
          r_golden <= w_misr;
          r_pass   <= 1'b1;
        end else begin
          r_pass <= (w_misr == r_golden);
        end
      end
    end
  end

  assign cut_sdi = (r_state == SHIFT) ?
                   w_lfsr : '0;
  assign bistpass       = bistdone & r_pass;
  assign bist_signature = bistdone ? w_misr : '0;

endmodule

// File: tb/tb_multi_chain_bist_controller.sv
// Self-checking bench: scan-chain CUT model plus pattern-level BIST model.
// Small instance for function/abort/reset, near-default instance for hold.
module tb_multi_chain_bist_controller;

  localparam int NC  = 2;
  localparam int CL  = 4;
  localparam int NP  = 3;
  localparam int SW  = 16;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] GOLD = 16'h5A3C;
  localparam int LAT = 1 + NP * (CL + 1) + CL + 1;

  localparam int NCB  = 4;
  localparam int CLB  = 229;
  localparam int NPB  = 20;
  localparam int LATB = 1 + NPB * (CLB + 1) + CLB + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          bistmode;
  logic          bist_learn;
  logic [NC-1:0] cut_sdo;
  logic          cut_scanmode;
  logic [NC-1:0] cut_sdi;
  logic          bist_busy;
  logic          bistdone;
  logic          bistpass;
  logic [SW-1:0] bist_signature;

  logic           bistmode_b;
  logic           learn_b;
  logic [NCB-1:0] sdo_b;
  logic           scan_b;
  logic [NCB-1:0] sdi_b;
  logic           busy_b;
  logic           done_b;
  logic           pass_b;
  logic [15:0]    sig_b;

  multi_chain_bist_controller #(
    .NUM_CHAINS   (NC),
    .CHAIN_LEN    (CL),
    .NUM_PATTERNS (NP),
    .SIG_W        (SW),
    .LFSR_SEED    (SEED),
    .GOLDEN_SIG   (GOLD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bistmode       (bistmode),
    .bist_learn     (bist_learn),
    .cut_sdo        (cut_sdo),
    .cut_scanmode   (cut_scanmode),
    .cut_sdi        (cut_sdi),
    .bist_busy      (bist_busy),
    .bistdone       (bistdone),
    .bistpass       (bistpass),
    .bist_signature (bist_signature)
  );

  multi_chain_bist_controller #(
    .NUM_PATTERNS (NPB)
  ) dut_b (
    .clk            (clk),
    .rst            (rst),
    .bistmode       (bistmode_b),
    .bist_learn     (learn_b),
    .cut_sdo        (sdo_b),
    .cut_scanmode   (scan_b),
    .cut_sdi        (sdi_b),
    .bist_busy      (busy_b),
    .bistdone       (done_b),
    .bistpass       (pass_b),
    .bist_signature (sig_b)
  );

  // CUT: NC scan chains, capture is a keyed nonlinear update.
  logic [CL-1:0] chain [NC];
  logic [31:0]   key;
  logic [NC-1:0] stuck;
  logic          scramble;

  function automatic logic [CL-1:0] cap(
    input logic [CL-1:0] v,
    input int            ch,
    input logic [31:0]   k
  );
    logic [CL-1:0] r;
    for (int j = 0; j < CL; j++)
      r[j] = v[j] ^ (v[(j+1)%CL] & v[(j+2)%CL])
             ^ k[(ch*CL+j)%32];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (scramble)
        chain[i] <= CL'($urandom);
      else if (cut_scanmode)
        chain[i] <= {chain[i][CL-2:0], cut_sdi[i]};
      else
        chain[i] <= cap(chain[i], i, key);
    end
  end

  always @* begin
    cut_sdo = '0;
    for (int i = 0; i < NC; i++)
      cut_sdo[i] = chain[i][CL-1] & ~stuck[i];
  end

  always @(posedge clk) sdo_b <= NCB'($urandom);

  // Reference: x^16+x^15+x^13+x^4+1, left shift.
  function automatic logic [15:0] step(
    input logic [15:0] s
  );
    return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
  endfunction

  function automatic logic [15:0] model_sig(
    input logic [31:0] k,
    input logic [NC-1:0] sa
  );
    logic [CL-1:0] ch [NC];
    logic [15:0]   lf;
    logic [15:0]   mi;
    logic [NC-1:0] so;
    lf = SEED;
    mi = '0;
    for (int i = 0; i < NC; i++) ch[i] = '0;
    for (int p = 0; p < NP; p++) begin
      for (int c = 0; c < CL; c++) begin
        for (int i = 0; i < NC; i++)
          so[i] = ch[i][CL-1] & ~sa[i];
        if (p > 0) mi = step(mi) ^ 16'(so);
        for (int i = 0; i < NC; i++)
          ch[i] = {ch[i][CL-2:0], lf[i]};
        lf = step(lf);
      end
      for (int i = 0; i < NC; i++)
        ch[i] = cap(ch[i], i, k);
    end
    for (int c = 0; c < CL; c++) begin
      for (int i = 0; i < NC; i++)
        so[i] = ch[i][CL-1] & ~sa[i];
      mi = step(mi) ^ 16'(so);
      for (int i = 0; i < NC; i++)
        ch[i] = {ch[i][CL-2:0], 1'b0};
    end
    return mi;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic run_a(
    input  bit learn,
    output int lat,
    output int pulses
  );
    bit p1;
    bit p2;
    p1 = 1'b0;
    p2 = 1'b0;
    @(negedge clk);
    bist_learn = learn;
    bistmode   = 1'b1;
    @(posedge clk);
    lat    = 0;
    pulses = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (p2 && !p1 && cut_scanmode) pulses++;
      p2 = p1;
      p1 = cut_scanmode;
    end while (!bistdone && lat < LAT + 20);
  endtask

  task automatic end_run();
    @(negedge clk);
    bistmode = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clear", bistdone, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, bist_busy, 1'b0);
    chk({tag, "_done"}, bistdone, 1'b0);
    chk({tag, "_pass"}, bistpass, 1'b0);
    chk({tag, "_sig"}, bist_signature, '0);
    chk({tag, "_scan"}, cut_scanmode, 1'b0);
    chk({tag, "_sdi"}, cut_sdi, '0);
  endtask

  logic [15:0] exp_sig;
  logic [15:0] flt_sig;
  logic [15:0] held;
  int          lat;
  int          pul;
  int          tries;
  int          okc;

  initial begin
    rst        = 1'b0;
    bistmode   = 1'b0;
    bist_learn = 1'b0;
    bistmode_b = 1'b0;
    learn_b    = 1'b0;
    stuck      = '0;
    scramble   = 1'b1;
    tries      = 0;
    do begin
      key     = $urandom;
      exp_sig = model_sig(key, '0);
      flt_sig = model_sig(key, 2'b10);
      tries++;
    end while ((flt_sig == exp_sig ||
                exp_sig == GOLD) && tries < 200);

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst      = 1'b1;
    scramble = 1'b0;

    run_a(1'b0, lat, pul);
    chk("latency", lat, LAT);
    chk("capture_pulses", pul, 3);
    chk("first_sig", bist_signature, exp_sig);
    chk("first_pass", bistpass, exp_sig == GOLD);
    chk("done_busy", bist_busy, 1'b0);
    end_run();

    @(negedge clk) scramble = 1'b1;
    @(negedge clk) scramble = 1'b0;
    run_a(1'b1, lat, pul);
    chk("learn_done", bistdone, 1'b1);
    chk("learn_pass", bistpass, 1'b1);
    chk("learn_sig", bist_signature, exp_sig);
    end_run();

    run_a(1'b0, lat, pul);
    chk("cmp_pass", bistpass, 1'b1);
    chk("cmp_sig", bist_signature, exp_sig);
    end_run();

    stuck = 2'b10;
    run_a(1'b0, lat, pul);
    chk("stuck_pass", bistpass,
        flt_sig == exp_sig);
    chk("stuck_sig", bist_signature, flt_sig);
    chk("stuck_differs", bist_signature != exp_sig,
        1'b1);
    end_run();
    stuck = '0;

    @(negedge clk);
    bistmode = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_in_shift", cut_scanmode, 1'b1);
    chk("abort_busy_pre", bist_busy, 1'b1);
    @(negedge clk);
    bistmode = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("abort");
    run_a(1'b0, lat, pul);
    chk("rerun_pass", bistpass, 1'b1);
    chk("rerun_sig", bist_signature, exp_sig);
    end_run();

    @(negedge clk);
    bistmode = 1'b1;
    @(posedge clk);
    repeat (17) @(posedge clk);
    #1;
    chk("unload_scan", cut_scanmode, 1'b1);
    chk("unload_sdi", cut_sdi, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #1;
    chk("rst_override", bist_busy, 1'b0);
    @(negedge clk);
    bistmode = 1'b0;
    rst      = 1'b1;
    run_a(1'b0, lat, pul);
    chk("golden_reset_pass", bistpass,
        exp_sig == GOLD);
    chk("golden_reset_sig", bist_signature, exp_sig);
    end_run();

    @(negedge clk);
    learn_b    = 1'b1;
    bistmode_b = 1'b1;
    @(posedge clk);
    lat = 0;
    while (!done_b && lat < LATB + 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b_latency", lat, LATB);
    chk("b_learn_pass", pass_b, 1'b1);
    held = sig_b;
    okc  = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (done_b && !busy_b && sig_b == held)
        okc++;
    end
    chk("b_hold_done", okc, 300);
    @(negedge clk);
    bistmode_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_drop", done_b, 1'b0);
    @(negedge clk);
    bistmode_b = 1'b1;
    @(posedge clk);
    #1;
    chk("b_restart", busy_b, 1'b1);
    @(negedge clk);
    bistmode_b = 1'b0;
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_chain_bist_controller.md
MULTI_CHAIN_BIST_CONTROLLER -- requirements
Module: multi_chain_bist_controller

Interface
REQ-001 The block SHALL have parameter NUM_CHAINS, default 4, number of parallel scan chains (1..SIG_W).
REQ-002 The block SHALL have parameter CHAIN_LEN, default 229, flops per chain (>=2).
REQ-003 The block SHALL have parameter NUM_PATTERNS, default 2000, number of scan loads plus captures per run (>=1).
REQ-004 The block SHALL have parameter SIG_W, default 16, LFSR and MISR width.
REQ-005 The block SHALL have parameter LFSR_SEED, default 16'hACE1, the nonzero PRPG seed.
REQ-006 The block SHALL have parameter GOLDEN_SIG, default 0, the golden signature loaded at reset.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-009 The block SHALL have port bistmode, input, 1 bit: level run request; deassertion aborts.
REQ-010 The block SHALL have port bist_learn, input, 1 bit: sampled at start; 1 = store the signature as golden instead of comparing.
REQ-011 The block SHALL have port cut_sdo, input, NUM_CHAINS bits: chain scan outputs.
REQ-012 The block SHALL have port cut_scanmode, output, 1 bit: 1 = shift, 0 = functional capture.
REQ-013 The block SHALL have port cut_sdi, output, NUM_CHAINS bits: chain scan inputs.
REQ-014 The block SHALL have ports bist_busy, bistdone and bistpass, outputs, 1 bit each: run active, run finished, result.
REQ-015 The block SHALL have port bist_signature, output, SIG_W bits: final MISR value, valid while bistdone=1.

Function
REQ-016 The FSM SHALL use states IDLE, SEED, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE.
REQ-017 IDLE SHALL hold all outputs at 0 and move to SEED when bistmode=1, latching bist_learn.
REQ-018 SEED SHALL last 1 cycle: LFSR <= LFSR_SEED, MISR <= 0, pattern counter <= 0, shift counter <= 0, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly CHAIN_LEN cycles with cut_scanmode=1, driving cut_sdi[i] = LFSR bit i and advancing the LFSR each cycle.
REQ-020 During SHIFT the MISR SHALL compact cut_sdo, XORed into MISR bits [NUM_CHAINS-1:0], except during the first load, where it holds because the chain contents are unknown.
REQ-021 After SHIFT the FSM SHALL enter CAPTURE for 1 cycle with cut_scanmode=0 and LFSR/MISR holding, then increment the pattern counter.
REQ-022 After CAPTURE, if the pattern count < NUM_PATTERNS the FSM SHALL return to SHIFT, else go to UNLOAD.
REQ-023 UNLOAD SHALL last CHAIN_LEN cycles with cut_scanmode=1, cut_sdi=0, LFSR holding and MISR compacting.
REQ-024 COMPARE SHALL last 1 cycle: in learn mode, golden <= MISR and bistpass <= 1; otherwise bistpass <= (MISR == golden).
REQ-025 DONE SHALL hold bistdone=1, bistpass and bist_signature stable until bistmode=0, then go to IDLE.
REQ-026 Start-to-bistdone latency SHALL be 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 cycles.
REQ-027 bist_busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 If bistmode=0 in SEED, SHIFT, CAPTURE, UNLOAD or COMPARE, the FSM SHALL go to IDLE next cycle with bistdone=0, bistpass=0 and the golden register unchanged.
REQ-029 The LFSR SHALL be a maximal-length Fibonacci polynomial for SIG_W; the MISR SHALL use the same polynomial.
REQ-030 Counters SHALL be sized with $clog2 of their limits and SHALL never wrap within a run.
REQ-031 A new run SHALL need bistmode low for >=1 cycle; a held-high bistmode after DONE SHALL NOT restart.

Reset
REQ-032 With rst=0 at a clock edge, the FSM SHALL go to IDLE, all outputs to 0, LFSR to LFSR_SEED, MISR to 0, counters to 0 and golden to GOLDEN_SIG.
REQ-033 Reset SHALL override bistmode in the same cycle, including mid-run.

Structure
REQ-034 Package bist_pkg SHALL hold the state enum, per-width LFSR tap-mask function and default seed/width constants.
REQ-035 The block SHALL instantiate one sub-module, bist_lfsr_misr, parametrised by SIG_W and mode (PRPG/MISR), used twice.

Verification
REQ-036 Bench: NUM_CHAINS=2, CHAIN_LEN=4, NUM_PATTERNS=3, bistmode rises -> bistdone rises exactly 21 cycles later and cut_scanmode shows 3 single-cycle low pulses.
REQ-037 Bench: learn run, then compare run with identical CUT model -> learn bistpass=1, second bistpass=1, same bist_signature.
REQ-038 Bench: learn run, then a second run with cut_sdo[1] stuck-at-0 -> bistpass=0, signature differs.
REQ-039 Bench: bistmode dropped in cycle 7 of SHIFT -> IDLE next cycle, bistdone=0, golden unchanged; a rerun passes.
REQ-040 Bench: rst=0 during UNLOAD -> next cycle all outputs 0, golden == GOLDEN_SIG.
REQ-041 Bench: default parameters, bistmode held high after DONE -> bistdone stays 1 and no restart until bistmode toggles.
